// File: rtl/id_stage_if.sv
// Fetch -> decode -> execute handshake bundle for id_stage.
// CTRL_W must match the packed control-word layout inside id_stage.
interface id_stage_if #(parameter int CTRL_W = 20);
  logic              if_valid;
  logic [31:0]       if_instr;
  logic [31:0]       if_pc;
  logic              id_ready;
  logic              ex_ready;
  logic              flush;
  logic              id_valid;
  logic [CTRL_W-1:0] id_ctrl;
  logic [31:0]       id_imm;
  logic [4:0]        id_rs1;
  logic [4:0]        id_rs2;
  logic [4:0]        id_rd;
  logic [31:0]       id_pc;
  logic [2:0]        id_funct3;
  logic              id_illegal;

  modport master (
    output if_valid, if_instr, if_pc, ex_ready, flush,
    input  id_ready, id_valid, id_ctrl, id_imm, id_rs1, id_rs2, id_rd,
           id_pc, id_funct3, id_illegal
  );

  modport slave (
    input  if_valid, if_instr, if_pc, ex_ready, flush,
    output id_ready, id_valid, id_ctrl, id_imm, id_rs1, id_rs2, id_rd,
           id_pc, id_funct3, id_illegal
  );
endinterface

// File: rtl/id_stage.sv
// RV32I decode into a single output register: 1-cycle latency, holds while !ex_ready.
// ID_LOAD_USE_STALL_EN inserts a one-bubble load-use stall; undefined, hazard is tied 0.
module id_stage (
  input logic       clk,
  input logic       rst,
  id_stage_if.slave bus
);
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_REG   = 7'b0110011;
  localparam logic [6:0] OP_CSR   = 7'b1110011;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SRA = 3'd2;
  localparam logic [2:0] ALU_SUB = 3'd3;
  localparam logic [2:0] ALU_SRL = 3'd5;

  localparam logic [2:0] CMP_BLT  = 3'd4;
  localparam logic [2:0] CMP_BLTU = 3'd6;

  localparam logic       AM1_RS1 = 1'b0;
  localparam logic       AM1_PC  = 1'b1;
  localparam logic [2:0] AM2_I   = 3'd0;
  localparam logic [2:0] AM2_U   = 3'd1;
  localparam logic [2:0] AM2_B   = 3'd2;
  localparam logic [2:0] AM2_S   = 3'd3;
  localparam logic [2:0] AM2_J   = 3'd4;
  localparam logic [2:0] AM2_RS2 = 3'd5;
  localparam logic       CM2_RS2 = 1'b0;
  localparam logic       CM2_I   = 1'b1;

  localparam logic [1:0] PC_PLUS4 = 2'd0;
  localparam logic [1:0] PC_ALU   = 2'd1;
  localparam logic [1:0] PC_MOD2  = 2'd2;

  localparam logic [3:0] RF_ALU  = 4'd0;
  localparam logic [3:0] RF_BREN = 4'd1;
  localparam logic [3:0] RF_UIMM = 4'd2;
  localparam logic [3:0] RF_LW   = 4'd3;
  localparam logic [3:0] RF_PC4  = 4'd4;
  localparam logic [3:0] RF_LB   = 4'd5;
  localparam logic [3:0] RF_LBU  = 4'd6;
  localparam logic [3:0] RF_LH   = 4'd7;
  localparam logic [3:0] RF_LHU  = 4'd8;

  typedef struct packed {
    logic [2:0] aluop;
    logic [2:0] cmpop;
    logic       alumux1;
    logic [2:0] alumux2;
    logic       cmpmux2;
    logic [1:0] pcmux;
    logic [3:0] regfilemux;
    logic       read_mem;
    logic       write_mem;
    logic       write_reg;
  } ctrl_t;

  logic [31:0] instr;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [4:0]  rs1, rs2, rd;
  logic [31:0] i_imm, s_imm, b_imm, u_imm, j_imm;

  assign instr  = bus.if_instr;
  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];
  assign rd     = instr[11:7];
  assign i_imm  = {{21{instr[31]}}, instr[30:20]};
  assign s_imm  = {{21{instr[31]}}, instr[30:25], instr[11:7]};
  assign b_imm  = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
  assign u_imm  = {instr[31:12], 12'h000};
  assign j_imm  = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};

  ctrl_t       ctrl_dec;
  logic [31:0] imm_dec;
  logic        illegal_dec;

  always_comb begin
    ctrl_dec    = '0;
    imm_dec     = '0;
    illegal_dec = 1'b0;
    case (opcode)
      OP_IMM, OP_REG: begin
        ctrl_dec.aluop     = funct3;
        ctrl_dec.alumux1   = AM1_RS1;
        ctrl_dec.write_reg = 1'b1;
        if (opcode == OP_IMM) begin
          imm_dec          = i_imm;
          ctrl_dec.alumux2 = AM2_I;
          ctrl_dec.cmpmux2 = CM2_I;
        end else begin
          ctrl_dec.alumux2 = AM2_RS2;
          ctrl_dec.cmpmux2 = CM2_RS2;
        end
        // slt/sltu reuse the branch comparator; the ALU result is ignored
        case (funct3)
          3'b000: if (opcode == OP_REG && instr[30]) ctrl_dec.aluop = ALU_SUB;
          3'b010: begin ctrl_dec.cmpop = CMP_BLT;  ctrl_dec.regfilemux = RF_BREN; end
          3'b011: begin ctrl_dec.cmpop = CMP_BLTU; ctrl_dec.regfilemux = RF_BREN; end
          3'b101: ctrl_dec.aluop = instr[30] ? ALU_SRA : ALU_SRL;
          default: ;
        endcase
      end
      OP_LUI: begin
        imm_dec             = u_imm;
        ctrl_dec.regfilemux = RF_UIMM;
        ctrl_dec.write_reg  = 1'b1;
      end
      OP_AUIPC: begin
        imm_dec             = u_imm;
        ctrl_dec.alumux1    = AM1_PC;
        ctrl_dec.alumux2    = AM2_U;
        ctrl_dec.aluop      = ALU_ADD;
        ctrl_dec.regfilemux = RF_ALU;
        ctrl_dec.write_reg  = 1'b1;
      end
      OP_JAL: begin
        imm_dec             = j_imm;
        ctrl_dec.alumux1    = AM1_PC;
        ctrl_dec.alumux2    = AM2_J;
        ctrl_dec.pcmux      = PC_ALU;
        ctrl_dec.regfilemux = RF_PC4;
        ctrl_dec.write_reg  = 1'b1;
      end
      OP_JALR: begin
        imm_dec             = i_imm;
        ctrl_dec.alumux1    = AM1_RS1;
        ctrl_dec.alumux2    = AM2_I;
        ctrl_dec.pcmux      = PC_MOD2;
        ctrl_dec.regfilemux = RF_PC4;
        ctrl_dec.write_reg  = 1'b1;
      end
      OP_BR: begin
        imm_dec          = b_imm;
        ctrl_dec.cmpop   = funct3;
        ctrl_dec.cmpmux2 = CM2_RS2;
        ctrl_dec.alumux1 = AM1_PC;
        ctrl_dec.alumux2 = AM2_B;
        ctrl_dec.aluop   = ALU_ADD;
      end
      OP_LOAD: begin
        imm_dec            = i_imm;
        ctrl_dec.read_mem  = 1'b1;
        ctrl_dec.alumux2   = AM2_I;
        ctrl_dec.aluop     = ALU_ADD;
        ctrl_dec.write_reg = 1'b1;
        case (funct3)
          3'b000:  ctrl_dec.regfilemux = RF_LB;
          3'b001:  ctrl_dec.regfilemux = RF_LH;
          3'b100:  ctrl_dec.regfilemux = RF_LBU;
          3'b101:  ctrl_dec.regfilemux = RF_LHU;
          default: ctrl_dec.regfilemux = RF_LW;
        endcase
      end
      OP_STORE: begin
        imm_dec            = s_imm;
        ctrl_dec.write_mem = 1'b1;
        ctrl_dec.alumux2   = AM2_S;
        ctrl_dec.aluop     = ALU_ADD;
      end
      OP_CSR: begin
        illegal_dec    = 1'b1;
        ctrl_dec.pcmux = PC_PLUS4;
      end
      default: begin
        illegal_dec    = 1'b1;
        ctrl_dec.pcmux = PC_PLUS4;
      end
    endcase
    if (rd == 5'd0) ctrl_dec.write_reg = 1'b0;
  end

  logic        valid_q, valid_d;
  ctrl_t       ctrl_q, ctrl_d;
  logic [31:0] imm_q, imm_d;
  logic [4:0]  rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
  logic [31:0] pc_q, pc_d;
  logic [2:0]  funct3_q, funct3_d;
  logic        illegal_q, illegal_d;
  logic        hazard;
  logic        id_ready;

`ifdef ID_LOAD_USE_STALL_EN
  logic uses_rs2;
  assign uses_rs2 = (opcode == OP_REG) || (opcode == OP_BR) || (opcode == OP_STORE);
  assign hazard   = valid_q & ctrl_q.read_mem & (rd_q != 5'd0) & bus.if_valid &
                    ((rs1 == rd_q) | (uses_rs2 & (rs2 == rd_q)));
`else
  assign hazard = 1'b0;
`endif

  assign id_ready = (!valid_q | bus.ex_ready) & !hazard & !bus.flush;

  always_comb begin
    valid_d   = valid_q;
    ctrl_d    = ctrl_q;
    imm_d     = imm_q;
    rs1_d     = rs1_q;
    rs2_d     = rs2_q;
    rd_d      = rd_q;
    pc_d      = pc_q;
    funct3_d  = funct3_q;
    illegal_d = illegal_q;
    if (bus.flush) begin
      valid_d = 1'b0;
    end else if (id_ready) begin
      valid_d = bus.if_valid;
      if (bus.if_valid) begin
        ctrl_d    = ctrl_dec;
        imm_d     = imm_dec;
        rs1_d     = rs1;
        rs2_d     = rs2;
        rd_d      = rd;
        pc_d      = bus.if_pc;
        funct3_d  = funct3;
        illegal_d = illegal_dec;
      end
    end else if (hazard & bus.ex_ready) begin
      // load leaves for EX while the dependent op waits upstream: one bubble
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q   <= 1'b0;
      ctrl_q    <= '0;
      imm_q     <= '0;
      rs1_q     <= '0;
      rs2_q     <= '0;
      rd_q      <= '0;
      pc_q      <= '0;
      funct3_q  <= '0;
      illegal_q <= 1'b0;
    end else begin
      valid_q   <= valid_d;
      ctrl_q    <= ctrl_d;
      imm_q     <= imm_d;
      rs1_q     <= rs1_d;
      rs2_q     <= rs2_d;
      rd_q      <= rd_d;
      pc_q      <= pc_d;
      funct3_q  <= funct3_d;
      illegal_q <= illegal_d;
    end
  end

  assign bus.id_ready   = id_ready;
  assign bus.id_valid   = valid_q;
  assign bus.id_ctrl    = ctrl_q;
  assign bus.id_imm     = imm_q;
  assign bus.id_rs1     = rs1_q;
  assign bus.id_rs2     = rs2_q;
  assign bus.id_rd      = rd_q;
  assign bus.id_pc      = pc_q;
  assign bus.id_funct3  = funct3_q;
  assign bus.id_illegal = illegal_q;
endmodule

// File: tb/tb_id_stage.sv
// Scoreboard bench for id_stage: directed RV32I vectors with hand-computed decode results.
module tb_id_stage;
  logic clk;
  logic rst;

  id_stage_if bus ();
  id_stage dut (.clk(clk), .rst(rst), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] instr;
    logic [19:0] ctrl;
    logic [31:0] imm;
    logic        ill;
    logic [19:0] mask;
  } vec_t;

  typedef struct packed {
    logic [19:0] ctrl;
    logic [19:0] mask;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] pc;
    logic [2:0]  f3;
    logic        ill;
  } exp_t;

  vec_t vecs [14];
  exp_t q [$];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic logic [19:0] mk(input logic [2:0] aluop, input logic [2:0] cmpop,
                                     input logic am1, input logic [2:0] am2, input logic cm2,
                                     input logic [1:0] pcm, input logic [3:0] rfm,
                                     input logic rm, input logic wm, input logic wr);
    return {aluop, cmpop, am1, am2, cm2, pcm, rfm, rm, wm, wr};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic setv(input int i, input logic [31:0] instr, input logic [19:0] ctrl,
                      input logic [31:0] imm, input logic ill, input logic [19:0] mask);
    vecs[i] = {instr, ctrl, imm, ill, mask};
  endtask

  task automatic init_vecs();
    setv(0,  32'h402080B3, mk(3,0,0,5,0,0,0,0,0,1), 32'h0,        1'b0, 20'hFFFFF); // sub x1,x1,x2
    setv(1,  32'hFFB00193, mk(0,0,0,0,1,0,0,0,0,1), 32'hFFFFFFFB, 1'b0, 20'hFFFFF); // addi x3,x0,-5
    setv(2,  32'h00812283, mk(0,0,0,0,0,0,3,1,0,1), 32'h8,        1'b0, 20'hFFFFF); // lw x5,8(x2)
    setv(3,  32'h00128333, mk(0,0,0,5,0,0,0,0,0,1), 32'h0,        1'b0, 20'hFFFFF); // add x6,x5,x1
    setv(4,  32'h00712623, mk(0,0,0,3,0,0,0,0,1,0), 32'hC,        1'b0, 20'hFFFFF); // sw x7,12(x2)
    setv(5,  32'hFE208CE3, mk(0,0,1,2,0,0,0,0,0,0), 32'hFFFFFFF8, 1'b0, 20'hFFFFF); // beq x1,x2,-8
    setv(6,  32'h12345537, mk(0,0,0,0,0,0,2,0,0,1), 32'h12345000, 1'b0, 20'hFFFFF); // lui x10
    setv(7,  32'h010000EF, mk(0,0,1,4,0,1,4,0,0,1), 32'h10,       1'b0, 20'hFFFFF); // jal x1,+16
    setv(8,  32'h0000007F, 20'h0,                   32'h0,        1'b1, 20'hFFFFF); // opcode 0x7F
    setv(9,  32'h00208033, mk(0,0,0,5,0,0,0,0,0,0), 32'h0,        1'b0, 20'hFFFFF); // add x0,x1,x2
    setv(10, 32'h40325233, mk(2,0,0,5,0,0,0,0,0,1), 32'h0,        1'b0, 20'hFFFFF); // sra x4,x4,x3
    setv(11, 32'h004280E7, mk(0,0,0,0,0,2,4,0,0,1), 32'h4,        1'b0, 20'hFFFFF); // jalr x1,4(x5)
    setv(12, 32'h00000073, 20'h0,                   32'h0,        1'b1, 20'hFFFFF); // ecall
    setv(13, 32'h00512093, mk(0,4,0,0,1,0,1,0,0,1), 32'h5,        1'b0, 20'h1FFFF); // slti x1,x2,5
  endtask

  task automatic send(input int idx, input logic [31:0] pc, output int waited);
    exp_t        e;
    logic [31:0] ins;
    bit          ok;
    ins    = vecs[idx].instr;
    e.ctrl = vecs[idx].ctrl;
    e.mask = vecs[idx].mask;
    e.imm  = vecs[idx].imm;
    e.ill  = vecs[idx].ill;
    e.rs1  = ins[19:15];
    e.rs2  = ins[24:20];
    e.rd   = ins[11:7];
    e.f3   = ins[14:12];
    e.pc   = pc;
    bus.if_valid = 1'b1;
    bus.if_instr = ins;
    bus.if_pc    = pc;
    ok     = 1'b0;
    waited = 0;
    for (int k = 0; k < 40 && !ok; k++) begin
      @(negedge clk);
      waited++;
      if (bus.id_ready) begin
        q.push_back(e);
        ok = 1'b1;
      end
    end
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL accept_timeout: id_ready %b, required 1 for vector %0d", bus.id_ready, idx);
    end
    @(posedge clk);
    #1;
    bus.if_valid = 1'b0;
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst && bus.id_valid && bus.ex_ready) begin
      if (q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_output: pc %h presented, required none", bus.id_pc);
      end else begin
        e = q.pop_front();
        chk("ctrl",    {12'h0, bus.id_ctrl & e.mask}, {12'h0, e.ctrl & e.mask});
        chk("imm",     bus.id_imm,           e.imm);
        chk("rs1",     {27'h0, bus.id_rs1},  {27'h0, e.rs1});
        chk("rs2",     {27'h0, bus.id_rs2},  {27'h0, e.rs2});
        chk("rd",      {27'h0, bus.id_rd},   {27'h0, e.rd});
        chk("pc",      bus.id_pc,            e.pc);
        chk("funct3",  {29'h0, bus.id_funct3}, {29'h0, e.f3});
        chk("illegal", {31'h0, bus.id_illegal}, {31'h0, e.ill});
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int w;
    int stream [13];
    stream = '{0, 1, 2, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13};
    rst          = 1'b0;
    bus.if_valid = 1'b0;
    bus.if_instr = '0;
    bus.if_pc    = '0;
    bus.ex_ready = 1'b1;
    bus.flush    = 1'b0;
    init_vecs();

    repeat (2) @(negedge clk);
    chk("reset_valid",   {31'h0, bus.id_valid},   32'h0);
    chk("reset_ctrl",    {12'h0, bus.id_ctrl},    32'h0);
    chk("reset_imm",     bus.id_imm,              32'h0);
    chk("reset_pc",      bus.id_pc,               32'h0);
    chk("reset_illegal", {31'h0, bus.id_illegal}, 32'h0);
    chk("reset_ready",   {31'h0, bus.id_ready},   32'h1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("post_reset_ready", {31'h0, bus.id_ready}, 32'h1);
    @(posedge clk); #1;

    foreach (stream[i]) begin
      send(stream[i], 32'h1000 + 32'(4 * i), w);
      if (i == 0) chk("first_accept_wait", w, 1);
    end
    repeat (3) @(posedge clk);
    #1;

    // backpressure: held sub must stay put while a new instruction waits
    bus.ex_ready = 1'b0;
    send(0, 32'h2000, w);
    bus.if_valid = 1'b1;
    bus.if_instr = vecs[1].instr;
    bus.if_pc    = 32'h2004;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("bp_ready", {31'h0, bus.id_ready}, 32'h0);
      chk("bp_valid", {31'h0, bus.id_valid}, 32'h1);
      chk("bp_pc",    bus.id_pc,             32'h2000);
      chk("bp_ctrl",  {12'h0, bus.id_ctrl},  {12'h0, vecs[0].ctrl});
    end
    @(posedge clk); #1;
    bus.ex_ready = 1'b1;
    send(1, 32'h2004, w);
    chk("bp_resume_wait", w, 1);
    repeat (2) @(posedge clk);
    #1;

    // flush squashes both the held lw and the incoming lui
    bus.ex_ready = 1'b0;
    send(2, 32'h3000, w);
    bus.if_valid = 1'b1;
    bus.if_instr = vecs[6].instr;
    bus.if_pc    = 32'h3004;
    bus.flush    = 1'b1;
    @(negedge clk);
    chk("flush_ready", {31'h0, bus.id_ready}, 32'h0);
    @(posedge clk); #1;
    bus.flush    = 1'b0;
    bus.if_valid = 1'b0;
    q.delete(q.size() - 1);
    @(negedge clk);
    chk("flush_valid", {31'h0, bus.id_valid}, 32'h0);
    @(negedge clk);
    chk("flush_nothing_taken", {31'h0, bus.id_valid}, 32'h0);
    @(posedge clk); #1;
    bus.ex_ready = 1'b1;

    // load-use: lw x5 followed by add x6,x5,x1
    send(2, 32'h4000, w);
    send(3, 32'h4004, w);
`ifdef ID_LOAD_USE_STALL_EN
    chk("loaduse_wait", w, 2);
`else
    chk("loaduse_wait", w, 1);
`endif
    repeat (3) @(posedge clk);
    #1;

    // asynchronous reset while an instruction is held and another is offered
    bus.ex_ready = 1'b0;
    send(10, 32'h5000, w);
    bus.if_valid = 1'b1;
    bus.if_instr = vecs[11].instr;
    bus.if_pc    = 32'h5004;
    @(negedge clk); #2;
    rst = 1'b0;
    #1;
    chk("midrst_valid",  {31'h0, bus.id_valid},  32'h0);
    chk("midrst_ctrl",   {12'h0, bus.id_ctrl},   32'h0);
    chk("midrst_pc",     bus.id_pc,              32'h0);
    chk("midrst_rd",     {27'h0, bus.id_rd},     32'h0);
    chk("midrst_rs1",    {27'h0, bus.id_rs1},    32'h0);
    chk("midrst_funct3", {29'h0, bus.id_funct3}, 32'h0);
    q.delete();
    bus.if_valid = 1'b0;
    @(posedge clk); #2;
    rst          = 1'b1;
    bus.ex_ready = 1'b1;
    @(negedge clk);
    chk("midrst_ready", {31'h0, bus.id_ready}, 32'h1);
    chk("midrst_idle",  {31'h0, bus.id_valid}, 32'h0);
    @(posedge clk); #1;
    send(8, 32'h6000, w);
    send(0, 32'h6004, w);
    repeat (4) @(posedge clk);
    #1;

    chk("scoreboard_empty", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/id_stage.md
ID_STAGE -- requirements
Module: id_stage

Interface
REQ-001 clk  in  1  sole clock; all state updates on rising edge.
REQ-002 rst  in  1  reset, asynchronous assert, active-low (0 = reset).
REQ-003 if_valid  in  1  fetch presents an instruction.
REQ-004 if_instr  in  32  instruction word (rv32i_word).
REQ-005 if_pc  in  32  PC of if_instr.
REQ-006 id_ready  out  1  stage accepts if_instr this cycle.
REQ-007 ex_ready  in  1  execute stage consumes the output register this cycle.
REQ-008 flush  in  1  squash all held and incoming instructions (taken branch/jump).
REQ-009 id_valid  out  1  output register holds a live instruction.
REQ-010 id_ctrl  out  rv32i_control_word  decoded control word.
REQ-011 id_imm  out  32  immediate selected by opcode format (I/S/B/U/J), sign-extended.
REQ-012 id_rs1, id_rs2, id_rd  out  5 each  register indices (rv32i_reg).
REQ-013 id_pc  out  32  PC of held instruction; id_funct3  out  3  funct3 field.
REQ-014 id_illegal  out  1  held instruction has an opcode outside rv32i_opcode.

Function
REQ-015 Single-entry output register; id_ready = (!id_valid | ex_ready) & !hazard & !flush.
REQ-016 Transfer when if_valid & id_ready; output register loads decoded fields at next edge, id_valid <= 1.
REQ-017 If id_ready=1 and if_valid=0, id_valid <= 0; if id_ready=0 and no flush, register holds all outputs unchanged.
REQ-018 flush=1: id_valid <= 0 next edge regardless of ex_ready/if_valid; incoming instruction discarded; flush dominates hazard.
REQ-019 Latency: one cycle from accepted if_instr to id_valid.
REQ-020 op_imm/op_reg: aluop from funct3; op_reg add with instr[30]=1 -> alu_sub; sr with instr[30]=1 -> alu_sra else alu_srl; slt/sltu -> cmpop blt/bltu, regfilemux br_en, aluop don't-care.
REQ-021 op_imm: alumux2 i_imm, cmpmux2 i_imm; op_reg: alumux2 rs2_out, cmpmux2 rs2_out; both alumux1 rs1_out, write_reg=1.
REQ-022 op_lui: regfilemux u_imm; op_auipc: alumux1 pc_out, alumux2 u_imm, alu_add, regfilemux alu_out.
REQ-023 op_jal: alumux1 pc_out, alumux2 j_imm, pcmux alu_out; op_jalr: alumux1 rs1_out, alumux2 i_imm, pcmux alu_mod2; both regfilemux pc_plus4, write_reg=1.
REQ-024 op_br: cmpop=funct3, cmpmux2 rs2_out, alumux1 pc_out, alumux2 b_imm, alu_add, write_reg=0; pcmux resolved in EX.
REQ-025 op_load: read_mem=1, alumux2 i_imm, alu_add, regfilemux lb/lh/lw/lbu/lhu per funct3; op_store: write_mem=1, alumux2 s_imm, alu_add, write_reg=0.
REQ-026 write_reg forced 0 whenever rd=0.
REQ-027 Illegal opcode or op_csr: id_illegal=1, read_mem=write_mem=write_reg=0, pcmux pc_plus4 (NOP behaviour).
REQ-028 All fields not listed per opcode: 0 / first enum value.

Reset
REQ-029 rst=0 asynchronously clears id_valid, id_illegal, id_ctrl, id_imm, id_rs1/rs2/rd, id_pc, id_funct3 to 0; id_ready=1 combinationally after reset (unless flush).
REQ-030 Reset mid-transfer discards the instruction; first accept possible on first edge after rst=1.

Configuration
REQ-031 Macro ID_LOAD_USE_STALL_EN defined: hazard = id_valid & id_ctrl.read_mem & id_rd!=0 & if_valid & (rs1 of if_instr = id_rd | rs2 of if_instr = id_rd when opcode uses rs2); when hazard & ex_ready, id_valid <= 0 (one bubble), incoming held upstream.
REQ-032 Macro undefined: hazard tied 0; downstream forwarding owns load-use.

Verification
REQ-033 Reset: rst=0 mid-stream -> all outputs 0 immediately, id_ready=1 after release.
REQ-034 if_instr=0x40208033 (sub x0? use x1=x1-x2: 0x402080B3), ex_ready=1 -> next cycle id_valid=1, aluop alu_sub, rd=1, write_reg=1.
REQ-035 Backpressure: id_valid=1, ex_ready=0, new if_valid -> id_ready=0, outputs stable for N cycles; ex_ready=1 -> new instr loaded next edge.
REQ-036 flush=1 with if_valid=1 and held instr -> id_valid=0 next cycle, nothing accepted.
REQ-037 With ID_LOAD_USE_STALL_EN: lw x5 held, incoming add x6,x5,x1 -> one bubble cycle (id_valid=0), add appears the cycle after; without macro, no bubble.
REQ-038 Opcode 0x7F -> id_illegal=1, write_reg=0, read_mem=write_mem=0.
